entry_sequencer: RTL and testbench

- Control unit that sequences the byte-entry datapath.
- Synchronizes and edge-detects the active-low enter button, then writes NUM_WORDS switch bytes into the datapath register bank at consecutive addresses.
- After the last write it pulses a start to the compute stage, waits for done, and holds the result-valid state until the next press restarts collection.

---
 rtl/entry_sequencer.sv | 144 ++++++++++++++
 tb/tb_entry_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/entry_sequencer.sv
// Byte-entry sequencer: synchronizes the enter button, writes NUM_WORDS bytes, then runs compute.
// Optional build macro DEBOUNCE_EN replaces the edge detector with a stable-low debouncer.
module entry_sequencer #(
   parameter int NUM_WORDS       = 8,
   parameter int ADDR_W          = 3,
   parameter int DATA_W          = 8,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic              clk,
   input  logic              nreset,
   input  logic              nenter,
   input  logic [DATA_W-1:0] inputdata,
   input  logic              compute_done,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              start_compute,
   output logic              busy,
   output logic              result_valid,
   output logic [ADDR_W:0]   entry_count,
   output logic [1:0]        state_code
);

   typedef enum logic [1:0] {
      COLLECT   = 2'b00,
      START     = 2'b01,
      WAIT_DONE = 2'b10,
      SHOW      = 2'b11
   } state_t;

   localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(NUM_WORDS - 1);
   localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);

   logic s1_q, s2_q, s3_q;
   logic press_d, press_q;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         s1_q    <= 1'b1;
         s2_q    <= 1'b1;
         s3_q    <= 1'b1;
         press_q <= 1'b0;
      end else begin
         s1_q    <= nenter;
         s2_q    <= s1_q;
         s3_q    <= s2_q;
         press_q <= press_d;
      end
   end

`ifdef DEBOUNCE_EN
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DEBOUNCE_CYCLES);

   logic [CNT_W-1:0] cnt_q;

   // Counter saturates after firing, so a long low period yields a single event.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         cnt_q <= '0;
      end else if (s2_q != s3_q) begin
         cnt_q <= '0;
      end else if (!s2_q && (cnt_q != CNT_SAT)) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign press_d = !s2_q && (s2_q == s3_q) && (cnt_q == CNT_FIRE);
`else
   assign press_d = s3_q && !s2_q;
`endif

   state_t              state_q;
   logic                wr_en_q, start_compute_q, busy_q, result_valid_q;
   logic [ADDR_W-1:0]   wr_addr_q;
   logic [DATA_W-1:0]   wr_data_q;
   logic [ADDR_W:0]     entry_count_q;
   logic [1:0]          state_code_q;

   // state_q leads the visible state_code by one cycle so start_compute lands after the final write.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q         <= COLLECT;
         wr_en_q         <= 1'b0;
         wr_addr_q       <= '0;
         wr_data_q       <= '0;
         start_compute_q <= 1'b0;
         busy_q          <= 1'b0;
         result_valid_q  <= 1'b0;
         entry_count_q   <= '0;
         state_code_q    <= COLLECT;
      end else begin
         wr_en_q         <= 1'b0;
         start_compute_q <= 1'b0;
         case (state_q)
            COLLECT: begin
               if (press_q) begin
                  wr_en_q       <= 1'b1;
                  wr_addr_q     <= entry_count_q[ADDR_W-1:0];
                  wr_data_q     <= inputdata;
                  entry_count_q <= entry_count_q + ONE;
                  if (entry_count_q == LAST) state_q <= START;
               end
            end
            START: begin
               start_compute_q <= 1'b1;
               busy_q          <= 1'b1;
               state_code_q    <= START;
               state_q         <= WAIT_DONE;
            end
            WAIT_DONE: begin
               state_code_q <= WAIT_DONE;
               // A done seen while start_compute is still high belongs to the START cycle.
               if (compute_done && !start_compute_q) begin
                  state_q        <= SHOW;
                  state_code_q   <= SHOW;
                  busy_q         <= 1'b0;
                  result_valid_q <= 1'b1;
               end
            end
            SHOW: begin
               if (press_q) begin
                  state_q        <= COLLECT;
                  state_code_q   <= COLLECT;
                  result_valid_q <= 1'b0;
                  entry_count_q  <= '0;
               end
            end
            default: state_q <= COLLECT;
         endcase
      end
   end

   assign wr_en         = wr_en_q;
   assign wr_addr       = wr_addr_q;
   assign wr_data       = wr_data_q;
   assign start_compute = start_compute_q;
   assign busy          = busy_q;
   assign result_valid  = result_valid_q;
   assign entry_count   = entry_count_q;
   assign state_code    = state_code_q;

endmodule

// File: tb/tb_entry_sequencer.sv
// Directed bench for entry_sequencer with a write scoreboard and immediate-assertion checks.
module tb_entry_sequencer;
   localparam int AW = 3;
   localparam int DW = 8;
`ifdef DEBOUNCE_EN
   localparam int LAT = 19;
`else
   localparam int LAT = 3;
`endif

   logic          clk = 1'b0;
   logic          nreset = 1'b0;
   logic          nenter = 1'b1;
   logic [DW-1:0] inputdata = '0;
   logic          compute_done = 1'b0;
   logic          wr_en, start_compute, busy, result_valid;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [AW:0]   entry_count;
   logic [1:0]    state_code;

   int tests = 0;
   int fails = 0;
   int wr_seen = 0;
   int pushes = 0;
   int start_cnt = 0;
   int exp_cnt = 0;
   int wr_before;
   logic [AW+DW-1:0] sb_q[$];

   entry_sequencer #(.NUM_WORDS(8), .ADDR_W(AW), .DATA_W(DW), .DEBOUNCE_CYCLES(16)) dut (
      .clk(clk), .nreset(nreset), .nenter(nenter), .inputdata(inputdata),
      .compute_done(compute_done), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .start_compute(start_compute), .busy(busy), .result_valid(result_valid),
      .entry_count(entry_count), .state_code(state_code)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (nreset && wr_en) begin
         wr_seen++;
         if (sb_q.size() == 0) begin
            check("unexpected_wr", {29'd0, wr_addr}, 32'hFFFF_FFFF);
         end else begin
            logic [AW+DW-1:0] e;
            e = sb_q.pop_front();
            check("sb_addr", {29'd0, wr_addr}, {29'd0, e[AW+DW-1:DW]});
            check("sb_data", {24'd0, wr_data}, {24'd0, e[DW-1:0]});
         end
      end
      if (nreset && start_compute) start_cnt++;
   end

   // Drives a press and returns at E3 (+#1) with nenter still low.
   task automatic press(input logic [DW-1:0] d, input bit expw);
      @(negedge clk);
      inputdata = d;
      nenter = 1'b0;
      if (expw) begin
         sb_q.push_back({exp_cnt[AW-1:0], d});
         exp_cnt++;
         pushes++;
      end
      repeat (LAT) @(posedge clk);
      #1 check("pre_wr_low", {31'd0, wr_en}, 32'd0);
      @(posedge clk);
      #1 check("wr_at_latency", {31'd0, wr_en}, {31'd0, expw});
   endtask

   task automatic release_btn();
      @(negedge clk);
      nenter = 1'b1;
      repeat (4) @(posedge clk);
   endtask

   initial begin
      #12;
      check("reset_outputs", {wr_en, wr_addr, wr_data, start_compute, busy, result_valid,
                              entry_count, state_code}, 32'd0);
      @(negedge clk);
      nreset = 1'b1;
      repeat (3) @(posedge clk);

      for (int i = 0; i < 8; i++) begin
         press(8'h10 + 8'(i), 1'b1);
         if (i == 7) begin
            check("last_entry_count", {28'd0, entry_count}, 32'd8);
            check("last_state_collect", {30'd0, state_code}, 32'd0);
            @(posedge clk);
            #1 check("start_pulse", {31'd0, start_compute}, 32'd1);
            check("state_start", {30'd0, state_code}, 32'd1);
            check("busy_start", {31'd0, busy}, 32'd1);
            @(negedge clk);
            compute_done = 1'b1;
            @(posedge clk);
            #1 check("start_single", {31'd0, start_compute}, 32'd0);
            check("state_wait", {30'd0, state_code}, 32'd2);
            check("done_in_start_ignored", {31'd0, result_valid}, 32'd0);
            @(negedge clk);
            compute_done = 1'b0;
         end
         release_btn();
      end

      for (int i = 0; i < 3; i++) begin
         press(8'hE0 + 8'(i), 1'b0);
         release_btn();
      end
      check("wait_count_holds", {28'd0, entry_count}, 32'd8);
      check("wait_busy", {31'd0, busy}, 32'd1);
      check("wait_state", {30'd0, state_code}, 32'd2);
      @(negedge clk);
      compute_done = 1'b1;
      @(posedge clk);
      #1 check("result_valid", {31'd0, result_valid}, 32'd1);
      check("state_show", {30'd0, state_code}, 32'd3);
      check("show_not_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      compute_done = 1'b0;
      repeat (3) @(posedge clk);
      #1 check("show_count", {28'd0, entry_count}, 32'd8);

      exp_cnt = 0;
      press(8'h55, 1'b0);
      check("show_exit_state", {30'd0, state_code}, 32'd0);
      check("show_exit_count", {28'd0, entry_count}, 32'd0);
      check("show_exit_rv", {31'd0, result_valid}, 32'd0);
      release_btn();

      wr_before = wr_seen;
      press(8'hA0, 1'b1);
      repeat (46) @(posedge clk);
      #1 check("hold_one_write", wr_seen - wr_before, 32'd1);
      check("hold_count", {28'd0, entry_count}, 32'd1);
      release_btn();

      for (int i = 1; i < 5; i++) begin
         press(8'hB0 + 8'(i), 1'b1);
         release_btn();
      end
      check("five_written", {28'd0, entry_count}, 32'd5);

      @(posedge clk);
      #3 nreset = 1'b0;
      nenter = 1'b0;
      inputdata = 8'hC3;
      #1 check("async_reset", {wr_en, wr_addr, wr_data, start_compute, busy, result_valid,
                               entry_count, state_code}, 32'd0);
      exp_cnt = 0;
      @(negedge clk);
      nreset = 1'b1;
      sb_q.push_back({3'd0, 8'hC3});
      exp_cnt = 1;
      pushes++;
      repeat (LAT) @(posedge clk);
      #1 check("held_thru_reset_pre", {31'd0, wr_en}, 32'd0);
      @(posedge clk);
      #1 check("held_thru_reset_wr", {31'd0, wr_en}, 32'd1);
      check("post_reset_addr", {29'd0, wr_addr}, 32'd0);
      release_btn();

`ifdef DEBOUNCE_EN
      wr_before = wr_seen;
      @(negedge clk);
      nenter = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      nenter = 1'b1;
      repeat (30) @(posedge clk);
      #1 check("glitch_no_write", wr_seen - wr_before, 32'd0);
      press(8'hD1, 1'b1);
      release_btn();
`endif

      repeat (5) @(posedge clk);
      #1 check("sb_empty", sb_q.size(), 32'd0);
      check("write_total", wr_seen, pushes);
      check("start_once", start_cnt, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
